booth_seq_mult: RTL

Parametrised sequential signed Booth multiplier, successor to the combinational 5-bit Booth block. It performs one Booth recoding step per clock under a start/done handshake and produces the exact 2·WIDTH-bit two's-complement product for every operand pair, including the most-negative multiplicand. It sits in the datapath lab library as the shared multiply unit for accumulator/MAC blocks that tolerate multi-cycle latency.

---
 rtl/booth_seq_mult_if.sv | 11 +
 rtl/booth_seq_mult.sv | 82 ++++++++
 2 files changed

// File: rtl/booth_seq_mult_if.sv
// booth_seq_mult_if: start/done handshake and operand/result bus for booth_seq_mult
interface booth_seq_mult_if #(parameter int WIDTH = 5);
   logic                      start;
   logic signed [WIDTH-1:0]   m;
   logic signed [WIDTH-1:0]   q;
   logic                      busy;
   logic                      done;
   logic signed [2*WIDTH-1:0] product;
   modport master (output start, m, q, input busy, done, product);
   modport slave (input start, m, q, output busy, done, product);
endinterface

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential signed Booth multiplier, one recoding step per clock.
// Define BOOTH_RADIX4_EN for modified-Booth radix-4 recoding (half the steps).
module booth_seq_mult #(parameter int WIDTH = 5) (
   input logic             clk,
   input logic             rst,
   booth_seq_mult_if.slave bus
);
`ifdef BOOTH_RADIX4_EN
   localparam int LW = WIDTH + (WIDTH % 2);
   localparam int HW = WIDTH + 2;
   localparam int SH = 2;
   localparam int STEPS = LW / 2;
`else
   localparam int LW = WIDTH;
   localparam int HW = WIDTH + 1;
   localparam int SH = 1;
   localparam int STEPS = WIDTH;
`endif
   localparam int AW = HW + LW + 1;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   logic [1:0]              state;
   logic [5:0]              cnt;
   logic signed [WIDTH-1:0] m_r;
   logic signed [HW-1:0]    hi;
   logic [LW-1:0]           lo;
   logic                    ql;
   logic signed [HW-1:0]    ms;
   logic signed [HW-1:0]    add;
   logic signed [AW-1:0]    nxt;
   assign ms = HW'(m_r);
`ifdef BOOTH_RADIX4_EN
   logic [2:0]           sel;
   logic signed [HW-1:0] two;
   assign sel = {lo[1:0], ql};
   assign two = ms <<< 1;
   always_comb begin
      add = '0;
      add = (sel == 3'b001 || sel == 3'b010) ? ms :
            (sel == 3'b011) ? two :
            (sel == 3'b100) ? -two :
            (sel == 3'b101 || sel == 3'b110) ? -ms : '0;
   end
`else
   always_comb begin
      add = '0;
      add = (lo[0] && !ql) ? -ms : (!lo[0] && ql) ? ms : '0;
   end
`endif
   // the whole {hi, lo, qlast} shifts together so the product ends up in its low bits
   assign nxt = $signed({hi + add, lo, ql}) >>> SH;
   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         m_r         <= '0;
         hi          <= '0;
         lo          <= '0;
         ql          <= 1'b0;
         bus.product <= '0;
      end else if (state == RUN) begin
         hi  <= nxt[AW-1 -: HW];
         lo  <= nxt[LW:1];
         ql  <= nxt[0];
         cnt <= cnt + 6'd1;
         if (cnt == 6'(STEPS - 1)) begin
            state       <= DONE;
            bus.product <= nxt[2*WIDTH:1];
         end
      end else if (bus.start) begin
         state <= RUN;
         cnt   <= '0;
         m_r   <= bus.m;
         hi    <= '0;
         lo    <= LW'(bus.q);
         ql    <= 1'b0;
      end else begin
         state <= IDLE;
      end
   end
endmodule
